// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the SRAM bus slave.
//                FSM state encoding, SRAM strobe bundle and the legal range
//                of the per-half-word access length.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Active-low SRAM control strobes, bundled so they travel together
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
  } sram_strb_t;

  // All strobes deasserted
  localparam sram_strb_t c_strb_idle = 5'b11111;

  // Legal bounds for the access length; the lower bound leaves room for a
  // one-cycle setup, at least one write-pulse cycle and a one-cycle hold.
  localparam int c_wait_min = 3;
  localparam int c_wait_max = 15;

  // Which half-words a request touches: bit 0 = low half, bit 1 = high half.
  // Reads always fetch both halves; writes skip halves with no byte enabled.
  function automatic logic [1:0] halves_needed(input logic we,
                                               input logic [3:0] be);
    return {(~we) | (|be[3:2]), (~we) | (|be[1:0])};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_io_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_io_reg
//  Description : Output register bank for every SRAM-facing signal. Kept as
//                a plain flop per pin with no logic behind it so the flops
//                can be placed in the I/O cells.
//  Ports       : clk, rst_n          clock, async active-low reset
//                strb_d, addr_d,     next-cycle strobes, half-word address,
//                dq_o_d, dq_oe_d     write data and pad output enable
//                sram_*              registered pad outputs
//  Revision    : 1.0  initial release
// ============================================================================
module sram_io_reg
  import mem_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  sram_strb_t        strb_d,
  input  logic [ADDR_W:0]   addr_d,
  input  logic [15:0]       dq_o_d,
  input  logic              dq_oe_d,
  output logic [ADDR_W:0]   sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  sram_strb_t            strb_q;
  logic [ADDR_W:0]       addr_q;
  logic [15:0]           dq_o_q;
  logic                  dq_oe_q;

  // Reset drives every strobe inactive immediately, so an interrupted write
  // pulse is cut short without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q  <= c_strb_idle;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
    end else begin
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = strb_q.ce_n;
  assign sram_oe_n  = strb_q.oe_n;
  assign sram_we_n  = strb_q.we_n;
  assign sram_lb_n  = strb_q.lb_n;
  assign sram_ub_n  = strb_q.ub_n;

endmodule
`default_nettype wire

// File: rtl/mem_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sram_slave
//  Description : Bus slave serving 32-bit word reads/writes from a 16-bit
//                asynchronous SRAM. Each request becomes up to two half-word
//                accesses (low half first) of WAIT_CYCLES clocks each,
//                followed by a one-cycle bus_ack.
//  Ports       : clk, rst_n                      clock, async active-low reset
//                bus_req/we/addr/wdata/be        request from the bus master
//                bus_rdata, bus_ack              response to the bus master
//                sram_addr, sram_dq_o/_i/_oe     SRAM address and data pads
//                sram_ce_n/oe_n/we_n/lb_n/ub_n   SRAM strobes (active low)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_sram_slave
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_be,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic [ADDR_W:0]   sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  generate
    if (WAIT_CYCLES < c_wait_min || WAIT_CYCLES > c_wait_max) begin : g_bad_wait
      $error("mem_sram_slave: WAIT_CYCLES out of range 3..15");
    end
  endgenerate

  // Counter value loaded at the start of each access; it counts down to 0,
  // so the access cycle index is k = c_cnt_last - cnt.
  localparam logic [3:0] c_cnt_last = 4'(WAIT_CYCLES - 1);

  state_t              state_q,   state_d;
  logic [3:0]          cnt_q,     cnt_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic                we_q,      we_d;
  logic [31:0]         wdata_q,   wdata_d;
  logic [3:0]          be_q,      be_d;
  logic                need_hi_q, need_hi_d;
  logic [31:0]         rdata_q,   rdata_d;
  logic                ack_q,     ack_d;
  logic [1:0]          need;

  // Pad values for the next cycle, registered inside sram_io_reg
  sram_strb_t          io_strb_d;
  logic [ADDR_W:0]     io_addr_d;
  logic [15:0]         io_dq_d;
  logic                io_dq_oe_d;
  logic                acc_d;
  logic                half_d;
  logic [1:0]          be_half_d;

  // --------------------------------------------------------------------------
  // Sequencer: request latch, access counter and read data capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    need_hi_d = need_hi_q;
    rdata_d   = rdata_q;
    need      = halves_needed(bus_we, bus_be);

    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          addr_d    = bus_addr;
          we_d      = bus_we;
          wdata_d   = bus_wdata;
          be_d      = bus_be;
          need_hi_d = need[1];
          cnt_d     = c_cnt_last;
          if (need[0]) begin
            state_d = ST_ACC_LO;
          end else if (need[1]) begin
            state_d = ST_ACC_HI;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_ACC_LO: begin
        if (cnt_q == 4'd0) begin
          // Last cycle of the access: the SRAM output has settled for
          // WAIT_CYCLES-1 cycles since oe_n fell.
          if (!we_q) begin
            rdata_d[15:0] = sram_dq_i;
          end
          cnt_d   = c_cnt_last;
          state_d = need_hi_q ? ST_ACC_HI : ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_ACC_HI: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d[31:16] = sram_dq_i;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_d = (state_d == ST_DONE);
  end

  // --------------------------------------------------------------------------
  // Pad values derived from the *next* state so that, once registered, the
  // strobes line up exactly with the cycles spent in each access state.
  // --------------------------------------------------------------------------
  always_comb begin
    acc_d      = (state_d == ST_ACC_LO) || (state_d == ST_ACC_HI);
    half_d     = (state_d == ST_ACC_HI);
    be_half_d  = half_d ? be_d[3:2] : be_d[1:0];
    io_strb_d  = c_strb_idle;
    io_addr_d  = '0;
    io_dq_d    = '0;
    io_dq_oe_d = 1'b0;

    if (acc_d) begin
      io_strb_d.ce_n = 1'b0;
      io_addr_d      = {addr_d, half_d};
      if (we_d) begin
        io_dq_oe_d     = 1'b1;
        io_dq_d        = half_d ? wdata_d[31:16] : wdata_d[15:0];
        io_strb_d.lb_n = ~be_half_d[0];
        io_strb_d.ub_n = ~be_half_d[1];
        // Write pulse excludes the first and last cycle so address and data
        // are stable one cycle either side of it.
        io_strb_d.we_n = (cnt_d == 4'd0) || (cnt_d == c_cnt_last);
      end else begin
        io_strb_d.oe_n = 1'b0;
        io_strb_d.lb_n = 1'b0;
        io_strb_d.ub_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      need_hi_q <= 1'b0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      need_hi_q <= need_hi_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;

  sram_io_reg #(
    .ADDR_W (ADDR_W)
  ) u_io (
    .clk        (clk),
    .rst_n      (rst_n),
    .strb_d     (io_strb_d),
    .addr_d     (io_addr_d),
    .dq_o_d     (io_dq_d),
    .dq_oe_d    (io_dq_oe_d),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_lb_n  (sram_lb_n),
    .sram_ub_n  (sram_ub_n)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_sram_slave
//  Description : Self-checking bench for mem_sram_slave. Instance 0 uses
//                WAIT_CYCLES=3 against a behavioural SRAM; instance 1 uses
//                WAIT_CYCLES=5 for back-to-back reads.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_sram_slave;

  localparam int W0 = 3;
  localparam int W1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance 0 signals
  logic        b_req, b_we, b_ack;
  logic [17:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic [18:0] s_addr;
  logic [15:0] s_dq_o, s_dq_i;
  logic        s_dq_oe, s_ce_n, s_oe_n, s_we_n, s_lb_n, s_ub_n;

  // Instance 1 signals
  logic        c_req, c_we, c_ack;
  logic [17:0] c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic [3:0]  c_be;
  logic [18:0] t_addr;
  logic [15:0] t_dq_o, t_dq_i;
  logic        t_dq_oe, t_ce_n, t_oe_n, t_we_n, t_lb_n, t_ub_n;

  mem_sram_slave #(.ADDR_W(18), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr),
    .bus_wdata(b_wdata), .bus_be(b_be), .bus_rdata(b_rdata), .bus_ack(b_ack),
    .sram_addr(s_addr), .sram_dq_o(s_dq_o), .sram_dq_i(s_dq_i), .sram_dq_oe(s_dq_oe),
    .sram_ce_n(s_ce_n), .sram_oe_n(s_oe_n), .sram_we_n(s_we_n),
    .sram_lb_n(s_lb_n), .sram_ub_n(s_ub_n));

  mem_sram_slave #(.ADDR_W(18), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus_req(c_req), .bus_we(c_we), .bus_addr(c_addr),
    .bus_wdata(c_wdata), .bus_be(c_be), .bus_rdata(c_rdata), .bus_ack(c_ack),
    .sram_addr(t_addr), .sram_dq_o(t_dq_o), .sram_dq_i(t_dq_i), .sram_dq_oe(t_dq_oe),
    .sram_ce_n(t_ce_n), .sram_oe_n(t_oe_n), .sram_we_n(t_we_n),
    .sram_lb_n(t_lb_n), .sram_ub_n(t_ub_n));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Unwritten SRAM locations read back as a fixed function of their address
  function automatic logic [15:0] init_hw(input logic [18:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Behavioural SRAM contents driven by instance 0's pins
  logic [15:0] smem [int];
  function automatic logic [15:0] sram_rd(input logic [18:0] a);
    if (smem.exists(int'(a))) return smem[int'(a)];
    return init_hw(a);
  endfunction

  // Bus-level reference memory (half-words), updated from request fields only
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_hw(input logic [18:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_hw(a);
  endfunction

  // ---------------------------------------------------------------- monitor
  typedef struct {
    logic [18:0] a;
    logic [15:0] d;
    logic        lb_n;
    logic        ub_n;
  } pulse_t;
  pulse_t pulses[$];

  bit          active [2];
  int          pos    [2];
  logic [18:0] cur_a  [2];
  bit          we_seen[2];
  int          first_we[2];
  int          last_we[2];
  int          ce_cnt [2];

  task automatic end_access(input int i, input int w);
    chk("acc_len", pos[i] + 1, w);
    if (we_seen[i]) begin
      chk("we_first_k", first_we[i], 1);
      chk("we_last_k", last_we[i], w - 2);
    end
    active[i] = 1'b0;
  endtask

  task automatic mon(input int i, input int w, input logic ce_n, input logic oe_n,
                     input logic we_n, input logic lb_n, input logic ub_n,
                     input logic dq_oe, input logic [18:0] a, input logic [15:0] d);
    logic        ov;
    logic [15:0] hw;
    ov = dq_oe & ~oe_n;
    chk("dq_oe_vs_oe_n", ov, 1'b0);
    if (!rst_n) begin
      active[i] = 1'b0;
      return;
    end
    if (!ce_n) begin
      ce_cnt[i]++;
      if (active[i] && a != cur_a[i]) end_access(i, w);
      if (!active[i]) begin
        active[i] = 1'b1; pos[i] = 0; cur_a[i] = a; we_seen[i] = 1'b0;
      end else begin
        pos[i]++;
      end
      if (!we_n) begin
        if (!we_seen[i]) begin
          first_we[i] = pos[i];
          if (i == 0) pulses.push_back('{a, d, lb_n, ub_n});
        end
        we_seen[i] = 1'b1;
        last_we[i] = pos[i];
        if (i == 0 && dq_oe) begin
          hw = sram_rd(a);
          if (!lb_n) hw[7:0]  = d[7:0];
          if (!ub_n) hw[15:8] = d[15:8];
          smem[int'(a)] = hw;
        end
      end
    end else if (active[i]) begin
      end_access(i, w);
    end
  endtask

  always @(negedge clk) begin
    mon(0, W0, s_ce_n, s_oe_n, s_we_n, s_lb_n, s_ub_n, s_dq_oe, s_addr, s_dq_o);
    mon(1, W1, t_ce_n, t_oe_n, t_we_n, t_lb_n, t_ub_n, t_dq_oe, t_addr, t_dq_o);
    s_dq_i = (!s_ce_n && !s_oe_n) ? sram_rd(s_addr) : 16'hDEAD;
    t_dq_i = (!t_ce_n && !t_oe_n) ? init_hw(t_addr) : 16'hDEAD;
  end

  // ------------------------------------------------------------ bus driver
  task automatic do_txn(input logic we, input logic [17:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] got, output int lat);
    @(posedge clk); #1;
    pulses.delete();
    ce_cnt[0] = 0;
    b_req = 1'b1; b_we = we; b_addr = a; b_wdata = d; b_be = be;
    for (lat = 0; lat <= 100; lat++) begin
      @(negedge clk);
      if (b_ack) break;
    end
    if (!b_ack) chk("ack_timeout", 1'b0, 1'b1);
    got = b_rdata;
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", b_ack, 1'b0);
  endtask

  // Checks one completed transaction against the bus-level model and
  // applies its effect to the reference memory.
  task automatic verify(input logic we, input logic [17:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] got, input int lat);
    bit       need [2];
    int       n;
    int       k;
    logic [1:0]  strb_exp, strb_got;
    logic [15:0] hw;
    need[0] = !we || (be[1:0] != 2'b00);
    need[1] = !we || (be[3:2] != 2'b00);
    n = int'(need[0]) + int'(need[1]);
    chk("ack_latency", lat, n * W0 + 1);
    chk("ce_cycles", ce_cnt[0], n * W0);
    if (we) begin
      chk("pulse_count", pulses.size(), n);
      k = 0;
      for (int h = 0; h < 2; h++) begin
        if (need[h]) begin
          if (k < pulses.size()) begin
            chk("pulse_addr", pulses[k].a, {a, 1'(h)});
            chk("pulse_data", pulses[k].d, (h == 1) ? d[31:16] : d[15:0]);
            strb_exp = ~be[2*h +: 2];
            strb_got = {pulses[k].ub_n, pulses[k].lb_n};
            chk("pulse_ub_lb", strb_got, strb_exp);
          end
          k++;
          hw = ref_hw({a, 1'(h)});
          if (be[2*h])     hw[7:0]  = d[16*h +: 8];
          if (be[2*h + 1]) hw[15:8] = d[16*h + 8 +: 8];
          ref_mem[int'({a, 1'(h)})] = hw;
        end
      end
    end else begin
      chk("read_data", got, {ref_hw({a, 1'b1}), ref_hw({a, 1'b0})});
    end
  endtask

  typedef struct {
    bit          we;
    logic [17:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;
  vec_t vt [11];

  initial begin
    logic [31:0] got;
    int          lat;
    int          cyc;
    logic [4:0]  strb;
    logic [17:0] a_cur;
    logic        r_we;
    logic [17:0] r_a;
    logic [31:0] r_d;
    logic [3:0]  r_be;

    rst_n = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      strb = {s_ce_n, s_oe_n, s_we_n, s_lb_n, s_ub_n};
      chk("idle_strobes", strb, 5'b11111);
      chk("idle_dq_oe", s_dq_oe, 1'b0);
      chk("idle_ack", b_ack, 1'b0);
      chk("idle_rdata", b_rdata, 32'h0);
      strb = {t_ce_n, t_oe_n, t_we_n, t_lb_n, t_ub_n};
      chk("idle_strobes_w5", strb, 5'b11111);
    end

    // Directed vectors
    vt[0]  = '{1'b1, 18'h10, 32'hDEADBEEF, 4'hF, 32'h0,         7};
    vt[1]  = '{1'b0, 18'h10, 32'h0,        4'h0, 32'hDEADBEEF,  7};
    vt[2]  = '{1'b1, 18'h05, 32'hDEADBEEF, 4'hF, 32'h0,         7};
    vt[3]  = '{1'b1, 18'h05, 32'h00AA0000, 4'h4, 32'h0,         4};
    vt[4]  = '{1'b0, 18'h05, 32'h0,        4'h0, 32'hDEAABEEF,  7};
    vt[5]  = '{1'b1, 18'h07, 32'hCAFEF00D, 4'h0, 32'h0,         1};
    vt[6]  = '{1'b0, 18'h07, 32'h0,        4'h0, 32'h5A555A54,  7};
    vt[7]  = '{1'b1, 18'h20, 32'h12345678, 4'h3, 32'h0,         4};
    vt[8]  = '{1'b0, 18'h20, 32'h0,        4'h0, 32'h5A1B5678,  7};
    vt[9]  = '{1'b1, 18'h21, 32'hAABBCCDD, 4'h9, 32'h0,         7};
    vt[10] = '{1'b0, 18'h21, 32'h0,        4'h0, 32'hAA195ADD,  7};

    for (int i = 0; i < 11; i++) begin
      do_txn(vt[i].we, vt[i].a, vt[i].d, vt[i].be, got, lat);
      chk("tbl_latency", lat, vt[i].exp_lat);
      if (!vt[i].we) chk("tbl_rdata", got, vt[i].exp_rd);
      verify(vt[i].we, vt[i].a, vt[i].d, vt[i].be, got, lat);
    end

    // Random traffic over a small window so reads hit earlier writes
    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_a  = 18'($urandom_range(0, 15));
      r_d  = $urandom;
      r_be = 4'($urandom_range(0, 15));
      do_txn(r_we, r_a, r_d, r_be, got, lat);
      verify(r_we, r_a, r_d, r_be, got, lat);
    end

    // Reset during k=1 of the low-half write
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 18'h30; b_wdata = 32'h01234567; b_be = 4'hF;
    repeat (3) @(negedge clk);
    chk("pre_reset_we_n", s_we_n, 1'b0);
    rst_n = 1'b0;
    #1;
    strb = {s_ce_n, s_oe_n, s_we_n, s_lb_n, s_ub_n};
    chk("rst_strobes", strb, 5'b11111);
    chk("rst_dq_oe", s_dq_oe, 1'b0);
    chk("rst_sram_addr", s_addr, 19'h0);
    chk("rst_dq_o", s_dq_o, 16'h0);
    chk("rst_ack", b_ack, 1'b0);
    chk("rst_rdata", b_rdata, 32'h0);
    @(negedge clk);
    b_req = 1'b0;
    rst_n = 1'b1;
    do_txn(1'b0, 18'h30, 32'h0, 4'h0, got, lat);
    chk("post_reset_read_latency", lat, 2 * W0 + 1);

    // Back-to-back reads on the WAIT_CYCLES=5 instance with bus_req held high
    @(posedge clk); #1;
    a_cur = 18'($urandom_range(0, 1023));
    c_addr = a_cur; c_we = 1'b0; c_req = 1'b1;
    for (int n = 0; n < 6; n++) begin
      for (cyc = 0; cyc <= 60; cyc++) begin
        @(negedge clk);
        if (c_ack) break;
      end
      chk("b2b_ack_spacing", cyc, 2 * W1 + 1);
      chk("b2b_rdata", c_rdata, {init_hw({a_cur, 1'b1}), init_hw({a_cur, 1'b0})});
      @(posedge clk); #1;
      a_cur = 18'($urandom_range(0, 1023));
      c_addr = a_cur;
    end
    c_req = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_sram_slave.md
# mem_sram_slave

Bus responder that serves 32-bit word read/write requests from the system bus master out of an external asynchronous 16-bit SRAM. Each bus transaction splits into up to two half-word SRAM accesses, low half first, each lasting a programmable number of clock cycles. The block sits between the bus master's memory port and the board SRAM pins, and is the slave end of the master's request/acknowledge protocol.

## Interface
Parameters:
- ADDR_W, 18: bus word-address width; the SRAM address is ADDR_W+1 bits.
- WAIT_CYCLES, 3: clock cycles per half-word SRAM access; legal range 3..15.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bus_req  in  1  request valid; held with all request fields stable until bus_ack
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  ADDR_W  word address
- bus_wdata  in  32  write data
- bus_be  in  4  byte enables; bit n covers bits [8n+7:8n]
- bus_rdata  out  32  read data; valid only in the bus_ack cycle of a read
- bus_ack  out  1  one-cycle completion pulse
- sram_addr  out  ADDR_W+1  half-word address = {bus_addr, half}
- sram_dq_o  out  16  write data to pad
- sram_dq_i  in  16  read data from pad
- sram_dq_oe  out  1  pad output enable
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  SRAM strobes, active low

## Operation
- FSM states: IDLE, ACC_LO, ACC_HI, DONE.
- IDLE: if bus_req, latch all request fields. Next state:
  - ACC_LO if the access needs the low half;
  - else ACC_HI if it needs the high half;
  - else DONE.
- Half needed:
  - reads: always both halves;
  - writes: low half iff bus_be[1:0]≠0, high half iff bus_be[3:2]≠0.
- ACC_x lasts exactly WAIT_CYCLES cycles; cycle index k = 0..WAIT_CYCLES-1 comes from a 4-bit down-counter.
- During ACC_x:
  - sram_ce_n = 0; sram_addr = {addr, x}; all SRAM outputs are registered.
  - Read: sram_oe_n = 0, lb_n = ub_n = 0, dq_oe = 0. On k = WAIT_CYCLES-1, capture sram_dq_i into bus_rdata[15:0] (LO) or bus_rdata[31:16] (HI).
  - Write: dq_oe = 1, dq_o = the matching wdata half, lb_n/ub_n = inverted be pair, sram_we_n = 0 only for k = 1..WAIT_CYCLES-2. Address and data are therefore stable one cycle before and after the write pulse.
- ACC_LO goes to ACC_HI if the high half is needed, else to DONE.
- ACC_HI goes to DONE.
- DONE: bus_ack = 1 for one cycle, strobes inactive, then IDLE. A request still asserted in the cycle after DONE is treated as a new transaction.
- Write with bus_be = 0000: no SRAM cycle at all; IDLE → DONE, acked.
- bus_rdata holds its value between transactions. It is undefined for writes.
- Async reset at any point, including mid-write: state = IDLE, bus_ack = 0, bus_rdata = 0, sram_ce_n/oe_n/we_n/lb_n/ub_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_o = 0. A half-finished write is abandoned; any SRAM contents it left are not guaranteed.

## Timing
- Cycle 0 is the first cycle with bus_req = 1 in IDLE.
- Read, or write touching both halves: bus_ack at cycle 2·WAIT_CYCLES+1 (7 with the default).
- Single-half write: bus_ack at cycle WAIT_CYCLES+1 (4).
- be = 0000 write: bus_ack at cycle 1.
- Back-to-back requests: at least one IDLE cycle between bus_ack and the next cycle 0.
- sram_we_n is never low in the first or last cycle of an access.
- sram_dq_oe and sram_oe_n are never both active in the same cycle.

## Structure
- Shared package mem_pkg: FSM state encoding, SRAM strobe bundle typedef, WAIT_CYCLES legal bounds.
- One natural sub-module, sram_io_reg: registers all SRAM-facing outputs and the dq output enable so the synthesis tool can pack them into IOB flops.
- FSM, counter and data capture live in mem_sram_slave.

## Test plan
- Reset then idle: all strobes 1, dq_oe 0, bus_ack 0, bus_rdata 0 for 10 cycles.
- Write 0xDEADBEEF to addr 0x00010 with be 1111 → two we_n pulses at sram_addr 0x00020 then 0x00021 (dq 0xBEEF, 0xDEAD); ack at cycle 7. Read back → ack at cycle 7 with bus_rdata = 0xDEADBEEF.
- Write be 0100, data 0x00AA0000, to addr 5 → only ACC_HI runs: sram_addr 0x0000B, ub_n 1, lb_n 0, ack at cycle 4. Read → 0xDEAA xxxx byte merge matches SRAM model.
- Write be 0000 → no ce_n activity; ack at cycle 1.
- Assert rst_n low during k = 1 of an ACC_LO write: all strobes go high immediately and asynchronously. After release, a read completes normally with ack at cycle 7.
- WAIT_CYCLES = 5, continuous back-to-back reads: ack every 12 cycles. Each we_n/oe_n protocol check holds, and no overlap of dq_oe with oe_n.
